instr_fetch_unit: RTL and testbench

//  Front end of the multicycle datapath; the opcode-producing end of the control_unit interface.

---
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multicycle front end: fetches instruction words into IR, strobes the opcode,
// then applies control-unit PC/RA commands until the instruction completes.
module instr_fetch_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                INSTR_W     = 16,
    parameter int                OPCODE_W    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [INSTR_W-1:0]  mem_rdata,
    output logic [OPCODE_W-1:0] A,
    output logic                op_valid,
    output logic [INSTR_W-1:0]  IR,
    input  logic                cycle_done,
    input  logic                writePC,
    input  logic                PCsrc,
    input  logic                ImRPC,
    input  logic [ADDR_W-1:0]   ImR,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                writeRA,
    output logic [ADDR_W-1:0]   PC,
    output logic [ADDR_W-1:0]   RA,
    output logic                fault
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   ra_q, ra_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ra_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ra_q    <= ra_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ra_d    = ra_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                // RA captures the PC as it was before any same-cycle jump
                if (writeRA) ra_d = pc_q;
                if (writePC) begin
                    if (!PCsrc)     pc_d = pc_q + ADDR_W'(1);
                    else if (ImRPC) pc_d = ImR;
                    else            pc_d = branch_target;
                end
                if (cycle_done) state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req  = (state_q == S_FETCH);
    assign mem_addr = pc_q;
    assign op_valid = (state_q == S_DECODE);
    assign fault    = (state_q == S_FAULT);
    assign A        = ir_q[INSTR_W-1 -: OPCODE_W];
    assign IR       = ir_q;
    assign PC       = pc_q;
    assign RA       = ra_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed-vector bench for instr_fetch_unit: per-cycle table plus a
// hand-written memory-timeout fault sequence.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [3:0]  A;
    logic        op_valid;
    logic [15:0] IR;
    logic        cycle_done;
    logic        writePC;
    logic        PCsrc;
    logic        ImRPC;
    logic [15:0] ImR;
    logic [15:0] branch_target;
    logic        writeRA;
    logic [15:0] PC;
    logic [15:0] RA;
    logic        fault;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .A(A), .op_valid(op_valid), .IR(IR),
        .cycle_done(cycle_done), .writePC(writePC),
        .PCsrc(PCsrc), .ImRPC(ImRPC), .ImR(ImR),
        .branch_target(branch_target), .writeRA(writeRA),
        .PC(PC), .RA(RA), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, ack;
        logic [15:0] rdata;
        logic        cd, wpc, src, imsel;
        logic [15:0] imr, bt;
        logic        wra;
        logic        e_req, e_opv, e_flt;
        logic [3:0]  e_a;
        logic [15:0] e_ir, e_pc, e_ra;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst_n, ack, input logic [15:0] rdata,
                       input logic cd, wpc, src, imsel,
                       input logic [15:0] imr, bt, input logic wra,
                       input logic e_req, e_opv, e_flt, input logic [3:0] e_a,
                       input logic [15:0] e_ir, e_pc, e_ra);
        vec_t v;
        v.rst_n = rst_n; v.ack = ack; v.rdata = rdata;
        v.cd = cd; v.wpc = wpc; v.src = src; v.imsel = imsel;
        v.imr = imr; v.bt = bt; v.wra = wra;
        v.e_req = e_req; v.e_opv = e_opv; v.e_flt = e_flt; v.e_a = e_a;
        v.e_ir = e_ir; v.e_pc = e_pc; v.e_ra = e_ra;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst_n, ack, input logic [15:0] rdata,
                         input logic cd, wpc, src, imsel,
                         input logic [15:0] imr, bt, input logic wra);
        reset_n = rst_n; mem_ack = ack; mem_rdata = rdata;
        cycle_done = cd; writePC = wpc; PCsrc = src; ImRPC = imsel;
        ImR = imr; branch_target = bt; writeRA = wra;
    endtask

    initial begin
        drive(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        // rst ack rdata cd wpc src ims imr bt wra | req opv flt A IR PC RA
        add(0,0,16'h0000,0,0,0,0,16'h0000,16'h0000,0, 0,0,0,4'h0,16'h0000,16'h0000,16'h0000);
        add(0,0,16'h0000,0,0,0,0,16'h0000,16'h0000,0, 0,0,0,4'h0,16'h0000,16'h0000,16'h0000);
        add(1,0,16'h0000,0,0,0,0,16'h0000,16'h0000,0, 1,0,0,4'h0,16'h0000,16'h0000,16'h0000);
        add(1,1,16'h3A5C,0,0,0,0,16'h0000,16'h0000,0, 0,1,0,4'h3,16'h3A5C,16'h0001,16'h0000);
        add(1,0,16'h0000,0,0,0,0,16'h0000,16'h0000,0, 0,0,0,4'h3,16'h3A5C,16'h0001,16'h0000);
        add(1,0,16'h0000,0,1,0,0,16'h0000,16'h0000,0, 0,0,0,4'h3,16'h3A5C,16'h0002,16'h0000);
        add(1,0,16'h0000,0,1,0,0,16'h0000,16'h0000,0, 0,0,0,4'h3,16'h3A5C,16'h0003,16'h0000);
        add(1,0,16'h0000,0,1,0,0,16'h0000,16'h0000,0, 0,0,0,4'h3,16'h3A5C,16'h0004,16'h0000);
        add(1,0,16'h0000,0,1,0,0,16'h0000,16'h0000,0, 0,0,0,4'h3,16'h3A5C,16'h0005,16'h0000);
        add(1,0,16'h0000,1,1,1,1,16'h0040,16'h0999,1, 1,0,0,4'h3,16'h3A5C,16'h0040,16'h0005);
        add(1,0,16'h0000,1,1,1,1,16'h0077,16'h0999,1, 1,0,0,4'h3,16'h3A5C,16'h0040,16'h0005);
        add(1,0,16'h0000,0,0,0,0,16'h0000,16'h0000,0, 1,0,0,4'h3,16'h3A5C,16'h0040,16'h0005);
        add(1,0,16'h0000,0,0,0,0,16'h0000,16'h0000,0, 1,0,0,4'h3,16'h3A5C,16'h0040,16'h0005);
        add(1,0,16'h0000,0,0,0,0,16'h0000,16'h0000,0, 1,0,0,4'h3,16'h3A5C,16'h0040,16'h0005);
        add(1,1,16'hB001,0,0,0,0,16'h0000,16'h0000,0, 0,1,0,4'hB,16'hB001,16'h0041,16'h0005);
        add(1,1,16'h7777,0,0,0,0,16'h0000,16'h0000,0, 0,0,0,4'hB,16'hB001,16'h0041,16'h0005);
        add(1,0,16'h0000,0,1,1,1,16'hFFFF,16'h0000,0, 0,0,0,4'hB,16'hB001,16'hFFFF,16'h0005);
        add(1,0,16'h0000,0,1,0,0,16'h0000,16'h0000,0, 0,0,0,4'hB,16'hB001,16'h0000,16'h0005);
        add(1,0,16'h0000,0,1,1,0,16'h5555,16'h1234,0, 0,0,0,4'hB,16'hB001,16'h1234,16'h0005);
        add(1,0,16'h0000,1,1,0,0,16'h0000,16'h0000,1, 1,0,0,4'hB,16'hB001,16'h1235,16'h1234);
        add(1,1,16'h9ABC,0,0,0,0,16'h0000,16'h0000,0, 0,1,0,4'h9,16'h9ABC,16'h1236,16'h1234);
        add(1,0,16'h0000,1,1,1,1,16'h0808,16'h0000,1, 0,0,0,4'h9,16'h9ABC,16'h1236,16'h1234);
        add(1,0,16'h0000,1,0,0,0,16'h0000,16'h0000,0, 1,0,0,4'h9,16'h9ABC,16'h1236,16'h1234);
        add(0,0,16'h0000,0,0,0,0,16'h0000,16'h0000,0, 0,0,0,4'h0,16'h0000,16'h0000,16'h0000);
        add(1,1,16'hF00D,0,0,0,0,16'h0000,16'h0000,0, 1,0,0,4'h0,16'h0000,16'h0000,16'h0000);
        add(1,0,16'h0000,0,0,0,0,16'h0000,16'h0000,0, 1,0,0,4'h0,16'h0000,16'h0000,16'h0000);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst_n, vq[i].ack, vq[i].rdata, vq[i].cd, vq[i].wpc,
                  vq[i].src, vq[i].imsel, vq[i].imr, vq[i].bt, vq[i].wra);
            step();
            chk("mem_req", i, 16'(mem_req), 16'(vq[i].e_req));
            if (vq[i].e_req) chk("mem_addr", i, mem_addr, vq[i].e_pc);
            chk("op_valid", i, 16'(op_valid), 16'(vq[i].e_opv));
            chk("fault", i, 16'(fault), 16'(vq[i].e_flt));
            chk("A", i, 16'(A), 16'(vq[i].e_a));
            chk("IR", i, IR, vq[i].e_ir);
            chk("PC", i, PC, vq[i].e_pc);
            chk("RA", i, RA, vq[i].e_ra);
        end

        // Memory never acknowledges: fault on the 15th unacked FETCH cycle
        drive(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        step();
        chk("flt_rst_fault", 100, 16'(fault), 16'h0);
        reset_n = 1'b1;
        step();
        chk("flt_req_start", 101, 16'(mem_req), 16'h1);
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("flt_wait_fault", 101 + k, 16'(fault), 16'h0);
            chk("flt_wait_req", 101 + k, 16'(mem_req), 16'h1);
        end
        step();
        chk("flt_fault", 116, 16'(fault), 16'h1);
        chk("flt_req", 116, 16'(mem_req), 16'h0);
        drive(1, 1, 16'hCAFE, 1, 1, 1, 1, 16'h0123, 16'h0456, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flt_sticky", 117 + k, 16'(fault), 16'h1);
            chk("flt_opv", 117 + k, 16'(op_valid), 16'h0);
            chk("flt_req_lo", 117 + k, 16'(mem_req), 16'h0);
            chk("flt_pc", 117 + k, PC, 16'h0000);
            chk("flt_ra", 117 + k, RA, 16'h0000);
            chk("flt_ir", 117 + k, IR, 16'h0000);
        end
        drive(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        step();
        chk("flt_clear", 120, 16'(fault), 16'h0);
        chk("flt_pc_rst", 120, PC, 16'h0000);
        reset_n = 1'b1;
        step();
        chk("flt_refetch", 121, 16'(mem_req), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
